// File: rtl/ysyx_25030085_idu.sv
// Instruction decode stage: combinational RV32I/RV32E (+M) decoder feeding a
// one-entry pipeline register with valid/ready handshakes on both sides.
module ysyx_25030085_idu #(
  parameter int NREG = 32,
  parameter int EN_M = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_alu_op,
  output logic        out_alu_src,
  output logic        out_mem_rd,
  output logic        out_mem_wr,
  output logic [2:0]  out_mem_op,
  output logic [1:0]  out_wb_sel,
  output logic        out_reg_wr,
  output logic [1:0]  out_jump,
  output logic        out_is_br,
  output logic [2:0]  out_br_func,
  output logic [1:0]  out_exc
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready = !full || out_ready, so a held entry can be replaced in the same
  // cycle it leaves. While out_valid && !out_ready the payload is frozen.
  // flush empties the register and drops any same-cycle input transfer.

  logic        r_full;
  logic [31:0] r_pc, r_imm;
  logic [4:0]  r_rs1, r_rs2, r_rd, r_alu_op;
  logic        r_alu_src, r_mem_rd, r_mem_wr, r_reg_wr, r_is_br;
  logic [2:0]  r_mem_op, r_br_func;
  logic [1:0]  r_wb_sel, r_jump, r_exc;

  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm;
  logic [4:0]  w_rs1, w_rs2, w_rd, w_alu_op;
  logic        w_alu_src, w_mem_rd, w_mem_wr, w_reg_wr, w_is_br, w_ill;
  logic [2:0]  w_mem_op, w_br_func;
  logic [1:0]  w_wb_sel, w_jump, w_sys, w_exc;
  logic        w_in_fire, w_out_fire;

  assign w_opc   = in_inst[6:0];
  assign w_f3    = in_inst[14:12];
  assign w_f7    = in_inst[31:25];
  assign w_imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign w_imm_u = {in_inst[31:12], 12'b0};
  assign w_imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  assign in_ready   = !r_full || out_ready;
  assign out_valid  = r_full;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_full && out_ready;

  // Decode the incoming instruction into control fields and an exception code.
  always_comb begin
    w_imm = '0; w_rs1 = '0; w_rs2 = '0; w_rd = '0; w_alu_op = '0;
    w_alu_src = 1'b0; w_mem_rd = 1'b0; w_mem_wr = 1'b0; w_mem_op = '0;
    w_wb_sel = '0; w_reg_wr = 1'b0; w_jump = '0; w_is_br = 1'b0;
    w_br_func = '0; w_ill = 1'b0; w_sys = '0; w_exc = '0;
    case (w_opc)
      7'b0110111: begin // lui
        w_imm = w_imm_u; w_rd = in_inst[11:7]; w_alu_src = 1'b1;
        w_wb_sel = 2'd3; w_reg_wr = 1'b1;
      end
      7'b0010111: begin // auipc
        w_imm = w_imm_u; w_rd = in_inst[11:7]; w_alu_op = 5'd9;
        w_alu_src = 1'b1; w_reg_wr = 1'b1;
      end
      7'b1101111: begin // jal
        w_imm = w_imm_j; w_rd = in_inst[11:7]; w_alu_op = 5'd9;
        w_alu_src = 1'b1; w_wb_sel = 2'd2; w_reg_wr = 1'b1; w_jump = 2'd1;
      end
      7'b1100111: begin // jalr
        w_ill = (w_f3 != 3'd0);
        w_imm = w_imm_i; w_rs1 = in_inst[19:15]; w_rd = in_inst[11:7];
        w_alu_src = 1'b1; w_wb_sel = 2'd2; w_reg_wr = 1'b1; w_jump = 2'd2;
      end
      7'b1100011: begin // branches: condition is resolved downstream
        w_ill = (w_f3 == 3'd2) || (w_f3 == 3'd3);
        w_imm = w_imm_b; w_rs1 = in_inst[19:15]; w_rs2 = in_inst[24:20];
        w_alu_op = 5'd9; w_alu_src = 1'b1; w_is_br = 1'b1; w_br_func = w_f3;
      end
      7'b0000011: begin // loads
        w_ill = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
        w_imm = w_imm_i; w_rs1 = in_inst[19:15]; w_rd = in_inst[11:7];
        w_alu_src = 1'b1; w_mem_rd = 1'b1; w_mem_op = w_f3;
        w_wb_sel = 2'd1; w_reg_wr = 1'b1;
      end
      7'b0100011: begin // stores
        w_ill = (w_f3 > 3'd2);
        w_imm = w_imm_s; w_rs1 = in_inst[19:15]; w_rs2 = in_inst[24:20];
        w_alu_src = 1'b1; w_mem_wr = 1'b1; w_mem_op = w_f3;
      end
      7'b0010011: begin // register-immediate ALU
        w_imm = w_imm_i; w_rs1 = in_inst[19:15]; w_rd = in_inst[11:7];
        w_alu_src = 1'b1; w_reg_wr = 1'b1;
        case (w_f3)
          3'd0: w_alu_op = 5'd0;
          3'd1: begin w_alu_op = 5'd1; w_ill = (w_f7 != 7'h00); end
          3'd2: w_alu_op = 5'd2;
          3'd3: w_alu_op = 5'd3;
          3'd4: w_alu_op = 5'd4;
          3'd5: begin
            w_alu_op = (w_f7 == 7'h20) ? 5'd5 : 5'd6;
            w_ill    = (w_f7 != 7'h00) && (w_f7 != 7'h20);
          end
          3'd6: w_alu_op = 5'd7;
          3'd7: w_alu_op = 5'd8;
        endcase
      end
      7'b0110011: begin // register-register ALU and M extension
        w_rs1 = in_inst[19:15]; w_rs2 = in_inst[24:20]; w_rd = in_inst[11:7];
        w_reg_wr = 1'b1;
        if (w_f7 == 7'h00) begin
          case (w_f3)
            3'd0: w_alu_op = 5'd0;
            3'd1: w_alu_op = 5'd1;
            3'd2: w_alu_op = 5'd2;
            3'd3: w_alu_op = 5'd3;
            3'd4: w_alu_op = 5'd4;
            3'd5: w_alu_op = 5'd6;
            3'd6: w_alu_op = 5'd7;
            3'd7: w_alu_op = 5'd8;
          endcase
        end else if (w_f7 == 7'h20 && w_f3 == 3'd0) begin
          w_alu_op = 5'd10;
        end else if (w_f7 == 7'h20 && w_f3 == 3'd5) begin
          w_alu_op = 5'd5;
        end else if (w_f7 == 7'h01 && EN_M != 0) begin
          w_alu_op = {2'b10, w_f3};
        end else begin
          w_ill = 1'b1;
        end
      end
      7'b0001111: begin // fence: no architectural effect in this core
      end
      7'b1110011: begin // only ecall/ebreak are recognised
        if (in_inst == 32'h0010_0073)      w_sys = 2'd2;
        else if (in_inst == 32'h0000_0073) w_sys = 2'd3;
        else                               w_ill = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    // RV32E: any used register field pointing above x15 is illegal
    if (NREG == 16 && (w_rs1[4] || w_rs2[4] || w_rd[4])) w_ill = 1'b1;
    w_exc = w_ill ? 2'd1 : w_sys;
    // A trapping instruction carries only its PC and exception code
    if (w_exc != 2'd0) begin
      w_imm = '0; w_rs1 = '0; w_rs2 = '0; w_rd = '0; w_alu_op = '0;
      w_alu_src = 1'b0; w_mem_rd = 1'b0; w_mem_wr = 1'b0; w_mem_op = '0;
      w_wb_sel = '0; w_reg_wr = 1'b0; w_jump = '0; w_is_br = 1'b0;
      w_br_func = '0;
    end
    if (w_rd == 5'd0) w_reg_wr = 1'b0;
  end

  // One-entry pipeline register; flush outranks load/unload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0; r_pc <= '0; r_imm <= '0; r_rs1 <= '0; r_rs2 <= '0;
      r_rd <= '0; r_alu_op <= '0; r_alu_src <= 1'b0; r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0; r_mem_op <= '0; r_wb_sel <= '0; r_reg_wr <= 1'b0;
      r_jump <= '0; r_is_br <= 1'b0; r_br_func <= '0; r_exc <= '0;
    end else if (flush) begin
      r_full <= 1'b0;
    end else if (w_in_fire) begin
      r_full <= 1'b1; r_pc <= in_pc; r_imm <= w_imm; r_rs1 <= w_rs1;
      r_rs2 <= w_rs2; r_rd <= w_rd; r_alu_op <= w_alu_op;
      r_alu_src <= w_alu_src; r_mem_rd <= w_mem_rd; r_mem_wr <= w_mem_wr;
      r_mem_op <= w_mem_op; r_wb_sel <= w_wb_sel; r_reg_wr <= w_reg_wr;
      r_jump <= w_jump; r_is_br <= w_is_br; r_br_func <= w_br_func;
      r_exc <= w_exc;
    end else if (w_out_fire) begin
      r_full <= 1'b0;
    end
  end

  assign out_pc      = r_pc;
  assign out_imm     = r_imm;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_rd      = r_rd;
  assign out_alu_op  = r_alu_op;
  assign out_alu_src = r_alu_src;
  assign out_mem_rd  = r_mem_rd;
  assign out_mem_wr  = r_mem_wr;
  assign out_mem_op  = r_mem_op;
  assign out_wb_sel  = r_wb_sel;
  assign out_reg_wr  = r_reg_wr;
  assign out_jump    = r_jump;
  assign out_is_br   = r_is_br;
  assign out_br_func = r_br_func;
  assign out_exc     = r_exc;

endmodule

// File: tb/tb_ysyx_25030085_idu.sv
// Bench for the decode stage: an RV32IM instance and an RV32E/no-M instance
// share all inputs; a one-entry expected queue plus a behavioural decoder
// predicts handshake and payload of both.
module tb_ysyx_25030085_idu;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd, alu_op;
    logic        alu_src, mem_rd, mem_wr;
    logic [2:0]  mem_op;
    logic [1:0]  wb_sel;
    logic        reg_wr;
    logic [1:0]  jump;
    logic        is_br;
    logic [2:0]  br_func;
    logic [1:0]  exc;
  } pay_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, flush;
  logic [31:0] in_inst, in_pc;
  always #5 clk = ~clk;

  logic a_in_ready, a_out_valid, e_in_ready, e_out_valid;
  logic [31:0] a_pc, a_imm, e_pc, e_imm;
  logic [4:0] a_rs1, a_rs2, a_rd, a_alu_op, e_rs1, e_rs2, e_rd, e_alu_op;
  logic a_alu_src, a_mem_rd, a_mem_wr, a_reg_wr, a_is_br;
  logic e_alu_src, e_mem_rd, e_mem_wr, e_reg_wr, e_is_br;
  logic [2:0] a_mem_op, a_br_func, e_mem_op, e_br_func;
  logic [1:0] a_wb_sel, a_jump, a_exc, e_wb_sel, e_jump, e_exc;
  pay_t obs_a, obs_e;

  assign obs_a = {a_pc, a_imm, a_rs1, a_rs2, a_rd, a_alu_op, a_alu_src, a_mem_rd,
                  a_mem_wr, a_mem_op, a_wb_sel, a_reg_wr, a_jump, a_is_br, a_br_func, a_exc};
  assign obs_e = {e_pc, e_imm, e_rs1, e_rs2, e_rd, e_alu_op, e_alu_src, e_mem_rd,
                  e_mem_wr, e_mem_op, e_wb_sel, e_reg_wr, e_jump, e_is_br, e_br_func, e_exc};

  ysyx_25030085_idu #(.NREG(32), .EN_M(1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_imm(a_imm), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
    .out_alu_op(a_alu_op), .out_alu_src(a_alu_src), .out_mem_rd(a_mem_rd),
    .out_mem_wr(a_mem_wr), .out_mem_op(a_mem_op), .out_wb_sel(a_wb_sel),
    .out_reg_wr(a_reg_wr), .out_jump(a_jump), .out_is_br(a_is_br),
    .out_br_func(a_br_func), .out_exc(a_exc)
  );

  ysyx_25030085_idu #(.NREG(16), .EN_M(0)) u_dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(e_out_valid), .out_ready(out_ready),
    .out_pc(e_pc), .out_imm(e_imm), .out_rs1(e_rs1), .out_rs2(e_rs2), .out_rd(e_rd),
    .out_alu_op(e_alu_op), .out_alu_src(e_alu_src), .out_mem_rd(e_mem_rd),
    .out_mem_wr(e_mem_wr), .out_mem_op(e_mem_op), .out_wb_sel(e_wb_sel),
    .out_reg_wr(e_reg_wr), .out_jump(e_jump), .out_is_br(e_is_br),
    .out_br_func(e_br_func), .out_exc(e_exc)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];  // {pc, inst} of the entry expected in the register
  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Behavioural decoder: immediates by weighted bit sums, ops by lookup table.
  function automatic pay_t model(input logic [31:0] inst, input logic [31:0] pc,
                                 input int nreg, input int en_m);
    pay_t p;
    int f3, f7, exc, imm_i, imm_s, imm_b, imm_j;
    bit ill, use1, use2, used;
    int base_op [8];
    base_op = '{0, 1, 2, 3, 4, 6, 7, 8};
    p = '0; ill = 0; exc = 0; use1 = 0; use2 = 0; used = 0;
    f3 = int'(inst[14:12]);
    f7 = int'(inst[31:25]);
    imm_i = int'(inst[31:20]) - (inst[31] ? 4096 : 0);
    imm_s = int'({inst[31:25], inst[11:7]}) - (inst[31] ? 4096 : 0);
    imm_b = int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2
            - (inst[31] ? 4096 : 0);
    imm_j = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2
            - (inst[31] ? 1048576 : 0);
    case (inst[6:0])
      7'h37: begin used = 1; p.imm = inst & 32'hFFFF_F000; p.alu_src = 1; p.wb_sel = 3; p.reg_wr = 1; end
      7'h17: begin used = 1; p.imm = inst & 32'hFFFF_F000; p.alu_op = 9; p.alu_src = 1; p.reg_wr = 1; end
      7'h6F: begin
        used = 1; p.imm = 32'(imm_j); p.alu_op = 9; p.alu_src = 1;
        p.wb_sel = 2; p.reg_wr = 1; p.jump = 1;
      end
      7'h67: begin
        ill = (f3 != 0); use1 = 1; used = 1; p.imm = 32'(imm_i); p.alu_src = 1;
        p.wb_sel = 2; p.reg_wr = 1; p.jump = 2;
      end
      7'h63: begin
        ill = (f3 == 2 || f3 == 3); use1 = 1; use2 = 1; p.imm = 32'(imm_b);
        p.alu_op = 9; p.alu_src = 1; p.is_br = 1; p.br_func = inst[14:12];
      end
      7'h03: begin
        ill = (f3 inside {3, 6, 7}); use1 = 1; used = 1; p.imm = 32'(imm_i);
        p.alu_src = 1; p.mem_rd = 1; p.mem_op = inst[14:12]; p.wb_sel = 1; p.reg_wr = 1;
      end
      7'h23: begin
        ill = (f3 > 2); use1 = 1; use2 = 1; p.imm = 32'(imm_s);
        p.alu_src = 1; p.mem_wr = 1; p.mem_op = inst[14:12];
      end
      7'h13: begin
        use1 = 1; used = 1; p.imm = 32'(imm_i); p.alu_src = 1; p.reg_wr = 1;
        if (f3 == 1) begin p.alu_op = 1; ill = (f7 != 0); end
        else if (f3 == 5) begin
          if (f7 == 0) p.alu_op = 6;
          else if (f7 == 32) p.alu_op = 5;
          else ill = 1;
        end else p.alu_op = 5'(base_op[f3]);
      end
      7'h33: begin
        use1 = 1; use2 = 1; used = 1; p.reg_wr = 1;
        if (f7 == 0) p.alu_op = 5'(base_op[f3]);
        else if (f7 == 32 && f3 == 0) p.alu_op = 10;
        else if (f7 == 32 && f3 == 5) p.alu_op = 5;
        else if (f7 == 1 && en_m != 0) p.alu_op = 5'(16 + f3);
        else ill = 1;
      end
      7'h0F: ;
      7'h73: begin
        if (inst == 32'h0010_0073) exc = 2;
        else if (inst == 32'h0000_0073) exc = 3;
        else ill = 1;
      end
      default: ill = 1;
    endcase
    if (use1) p.rs1 = inst[19:15];
    if (use2) p.rs2 = inst[24:20];
    if (used) p.rd  = inst[11:7];
    if (int'(p.rs1) >= nreg || int'(p.rs2) >= nreg || int'(p.rd) >= nreg) ill = 1;
    if (ill) exc = 1;
    if (p.rd == 0) p.reg_wr = 0;
    if (exc != 0) begin p = '0; p.exc = 2'(exc); end
    p.pc = pc;
    return p;
  endfunction

  task automatic check_state();
    chk("a_in_ready", 128'(a_in_ready), 128'(exp_q.size() == 0 || out_ready));
    chk("e_in_ready", 128'(e_in_ready), 128'(exp_q.size() == 0 || out_ready));
    chk("a_out_valid", 128'(a_out_valid), 128'(exp_q.size() != 0));
    chk("e_out_valid", 128'(e_out_valid), 128'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("a_payload", 128'(obs_a), 128'(model(exp_q[0][31:0], exp_q[0][63:32], 32, 1)));
      chk("e_payload", 128'(obs_e), 128'(model(exp_q[0][31:0], exp_q[0][63:32], 16, 0)));
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    bit in_fire, out_fire;
    @(negedge clk);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    check_state();
    in_fire  = v && (exp_q.size() == 0 || ordy);
    out_fire = (exp_q.size() != 0) && ordy;
    if (fl) exp_q.delete();
    else begin
      if (out_fire) void'(exp_q.pop_front());
      if (in_fire) exp_q.push_back({pc, inst});
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int k;
    logic [6:0] opcs [10];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    r = $urandom();
    if ($urandom_range(0, 1) == 0) begin r[24] = 1'b0; r[19] = 1'b0; r[11] = 1'b0; end
    k = $urandom_range(0, 10);
    if (k < 10) r[6:0] = opcs[k];
    if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    if (r[6:0] == 7'h73) begin
      case ($urandom_range(0, 2))
        0: r = 32'h0010_0073;
        1: r = 32'h0000_0073;
        default: ;
      endcase
    end
    return r;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 128'(a_out_valid), 128'(0));
    chk("rst_payload_a", 128'(obs_a), 128'(0));
    chk("rst_payload_e", 128'(obs_e), 128'(0));
    rst = 1'b0;

    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("in_ready_after_rst", 128'(a_in_ready), 128'(1));

    // addi x1,x0,5
    step(1'b1, 32'h0050_0093, 32'h8000_0000, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("addi_valid", 128'(a_out_valid), 128'(1));
    chk("addi_rd", 128'(a_rd), 128'(1));
    chk("addi_imm", 128'(a_imm), 128'(5));
    chk("addi_alu_op", 128'(a_alu_op), 128'(0));
    chk("addi_alu_src", 128'(a_alu_src), 128'(1));
    chk("addi_reg_wr", 128'(a_reg_wr), 128'(1));

    // stall for three cycles with a waiting instruction
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h0220_8133, 32'h8000_0004, 1'b0, 1'b0);
      chk("hold_in_ready", 128'(a_in_ready), 128'(0));
      chk("hold_imm", 128'(a_imm), 128'(5));
      chk("hold_pc", 128'(a_pc), 128'(32'h8000_0000));
    end

    // back-to-back replacement: mul, addi x17, ebreak, beq
    step(1'b1, 32'h0220_8133, 32'h8000_0004, 1'b1, 1'b0);
    step(1'b1, 32'h0100_0893, 32'h8000_0008, 1'b1, 1'b0);
    chk("mul_valid", 128'(a_out_valid), 128'(1));
    chk("mul_alu_op", 128'(a_alu_op), 128'(16));
    chk("mul_noM_exc", 128'(e_exc), 128'(1));
    chk("mul_noM_reg_wr", 128'(e_reg_wr), 128'(0));
    step(1'b1, 32'h0010_0073, 32'h8000_000C, 1'b1, 1'b0);
    chk("x17_rv32i_exc", 128'(a_exc), 128'(0));
    chk("x17_rv32e_exc", 128'(e_exc), 128'(1));
    step(1'b1, 32'hFE00_0EE3, 32'h8000_0010, 1'b1, 1'b0);
    chk("ebreak_exc_a", 128'(a_exc), 128'(2));
    chk("ebreak_exc_e", 128'(e_exc), 128'(2));
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("beq_is_br", 128'(a_is_br), 128'(1));
    chk("beq_br_func", 128'(a_br_func), 128'(0));
    chk("beq_imm", 128'(a_imm), 128'(32'hFFFF_FFFC));

    // flush while full, with a same-cycle input
    step(1'b1, 32'h0050_0093, 32'h8000_0014, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_out_valid", 128'(a_out_valid), 128'(0));

    // reset asserted while holding an entry
    step(1'b1, 32'h0050_0093, 32'h8000_0018, 1'b1, 1'b0);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 128'(a_out_valid), 128'(1));
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 128'(a_out_valid), 128'(0));
    chk("async_rst_payload", 128'(obs_a), 128'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom(),
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
